// File: rtl/ntt_inverse.sv
// Inverse NTT engine: in-place Gentleman-Sande stages followed by an N^-1 scaling pass.
// Twiddles come from an external combinational zeta ROM, one port per butterfly lane.
module ntt_inverse #(
  parameter int N             = 256,
  parameter int WIDTH         = 32,
  parameter int Q             = 8380417,
  parameter int ADDR_WIDTH    = 8,
  parameter int PARALLEL      = 8,
  parameter int MULT_PIPELINE = 3,
  parameter int N_INV         = 8347681
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           done,
  output logic                           busy,
  input  logic                           load_coeff,
  input  logic [ADDR_WIDTH-1:0]          load_addr,
  input  logic [WIDTH-1:0]               load_data,
  input  logic [ADDR_WIDTH-1:0]          read_addr,
  output logic [WIDTH-1:0]               read_data,
  output logic [PARALLEL*ADDR_WIDTH-1:0] tw_addr,
  input  logic [PARALLEL*24-1:0]         tw_data
);

  localparam int LOGN  = ADDR_WIDTH;
  localparam int ISSUE = N / (2 * PARALLEL);
  localparam int DRN   = MULT_PIPELINE + 1;
  localparam int CW    = 16;
  localparam int MP    = MULT_PIPELINE;

  localparam logic [WIDTH-1:0]   QW   = WIDTH'(Q);
  localparam logic [WIDTH:0]     QW1  = (WIDTH+1)'(Q);
  localparam logic [2*WIDTH-1:0] QW2  = (2*WIDTH)'(Q);
  localparam logic [WIDTH-1:0]   NINV = WIDTH'(N_INV);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BFLY   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_SCALE  = 3'd3;
  localparam logic [2:0] S_SDRAIN = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  function automatic logic [WIDTH-1:0] mulmod(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    return WIDTH'(p % QW2);
  endfunction

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] stage;
  logic                  bfly;
  logic                  scale;
  logic                  issue;
  logic                  last_issue;
  logic                  last_drain;

  logic [WIDTH-1:0] mem [N];

  assign bfly       = state == S_BFLY;
  assign scale      = state == S_SCALE;
  assign issue      = bfly | scale;
  assign busy       = state != S_IDLE;
  assign done       = state == S_DONE;
  assign last_issue = cnt == CW'(ISSUE - 1);
  assign last_drain = cnt == CW'(DRN - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      stage <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_BFLY;
            cnt   <= '0;
            stage <= '0;
          end
        end
        S_BFLY: begin
          if (last_issue) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (last_drain) begin
            cnt <= '0;
            if (stage == ADDR_WIDTH'(LOGN - 1)) begin
              state <= S_SCALE;
            end else begin
              stage <= stage + ADDR_WIDTH'(1);
              state <= S_BFLY;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SCALE: begin
          if (last_issue) begin
            state <= S_SDRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SDRAIN: begin
          if (last_drain) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [ADDR_WIDTH-1:0]                s_eff;
  logic [PARALLEL-1:0][ADDR_WIDTH-1:0]  k, grp, pos, lo, hi, tw;
  logic [PARALLEL-1:0][WIDTH-1:0]       a, b, asum, diff;
  logic [PARALLEL-1:0][WIDTH:0]         sum;
  logic [PARALLEL-1:0][WIDTH-1:0]       x0, y0, x1, y1;

  // The scale pass reuses the stage-0 pairing: lane k owns 2k and 2k+1.
  always_comb begin
    s_eff = scale ? '0 : stage;
    k = '0; grp = '0; pos = '0; lo = '0; hi = '0; tw = '0;
    a = '0; b = '0; asum = '0; diff = '0; sum = '0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    for (int l = 0; l < PARALLEL; l++) begin
      k[l]   = ADDR_WIDTH'(cnt) * ADDR_WIDTH'(PARALLEL)
             + ADDR_WIDTH'(l);
      grp[l] = k[l] >> s_eff;
      pos[l] = k[l] & ((ADDR_WIDTH'(1) << s_eff) - ADDR_WIDTH'(1));
      lo[l]  = (grp[l] << (s_eff + ADDR_WIDTH'(1))) | pos[l];
      hi[l]  = lo[l] + (ADDR_WIDTH'(1) << s_eff);
      tw[l]  = bfly ? ADDR_WIDTH'((N >> s_eff) - 1) - grp[l] : '0;
      a[l]   = mem[lo[l]];
      b[l]   = mem[hi[l]];
      sum[l] = {1'b0, a[l]} + {1'b0, b[l]};
      asum[l] = (sum[l] >= QW1) ? WIDTH'(sum[l] - QW1)
                                : WIDTH'(sum[l]);
      diff[l] = (b[l] >= a[l]) ? b[l] - a[l] : b[l] + QW - a[l];
      if (scale) begin
        x0[l] = a[l];
        y0[l] = NINV;
        x1[l] = b[l];
        y1[l] = NINV;
      end else begin
        x0[l] = asum[l];
        y0[l] = WIDTH'(1);
        x1[l] = diff[l];
        y1[l] = WIDTH'(tw_data[l*24 +: 24]);
      end
    end
  end

  assign tw_addr = tw;

  logic [MP:0]                                vld;
  logic [PARALLEL-1:0][WIDTH-1:0]             ox0, oy0, ox1, oy1;
  logic [MP:0][PARALLEL-1:0][ADDR_WIDTH-1:0]  plo, phi;
  logic [MP-1:0][PARALLEL-1:0][WIDTH-1:0]     pr0, pr1;

  always_ff @(posedge clk) begin
    if (!rst_n) vld <= '0;
    else        vld <= {vld[MP-1:0], issue};
  end

  always_ff @(posedge clk) begin
    ox0    <= x0;
    oy0    <= y0;
    ox1    <= x1;
    oy1    <= y1;
    plo[0] <= lo;
    phi[0] <= hi;
    for (int i = 1; i <= MP; i++) begin
      plo[i] <= plo[i-1];
      phi[i] <= phi[i-1];
    end
    for (int l = 0; l < PARALLEL; l++) begin
      pr0[0][l] <= mulmod(ox0[l], oy0[l]);
      pr1[0][l] <= mulmod(ox1[l], oy1[l]);
    end
    for (int i = 1; i < MP; i++) begin
      pr0[i] <= pr0[i-1];
      pr1[i] <= pr1[i-1];
    end
  end

  // Writeback is gated by rst_n so an abort stops memory updates at once.
  always_ff @(posedge clk) begin
    if (load_coeff && !busy) mem[load_addr] <= load_data;
    if (rst_n && vld[MP]) begin
      for (int l = 0; l < PARALLEL; l++) begin
        mem[plo[MP][l]] <= pr0[MP-1][l];
        mem[phi[MP][l]] <= pr1[MP-1][l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) read_data <= '0;
    else        read_data <= mem[read_addr];
  end

endmodule

// File: tb/tb_ntt_inverse.sv
// Directed bench for ntt_inverse with an attached zeta ROM and
// a forward-NTT reference used to build round-trip inputs.
module tb_ntt_inverse;

  localparam int N  = 256;
  localparam int W  = 32;
  localparam int Q  = 8380417;
  localparam int AW = 8;
  localparam int P  = 8;
  localparam int DONE_AT = 181;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              done;
  logic              busy;
  logic              load_coeff;
  logic [AW-1:0]     load_addr;
  logic [W-1:0]      load_data;
  logic [AW-1:0]     read_addr;
  logic [W-1:0]      read_data;
  logic [P*AW-1:0]   tw_addr;
  logic [P*24-1:0]   tw_data;

  int tests = 0;
  int fails = 0;

  int unsigned zeta [N];
  int unsigned fwd  [N];
  int unsigned img  [N];
  int unsigned gold [N];

  always #5 clk = ~clk;

  ntt_inverse dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .load_coeff (load_coeff),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .tw_addr    (tw_addr),
    .tw_data    (tw_data)
  );

  always_comb begin
    tw_data = '0;
    for (int l = 0; l < P; l++)
      tw_data[l*24 +: 24] = 24'(zeta[tw_addr[l*AW +: AW]]);
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned brv8(input int unsigned x);
    int unsigned r = 0;
    for (int i = 0; i < 8; i++)
      if (x[i]) r |= 32'd1 << (7 - i);
    return r;
  endfunction

  task automatic build_tables();
    longint z, t;
    longint v [N];
    int kk;
    for (int k = 0; k < N; k++) begin
      z = 1;
      for (int e = 0; e < int'(brv8(k)); e++) z = (z * 1753) % Q;
      zeta[k] = int'(z);
    end
    for (int i = 0; i < N; i++) v[i] = i;
    kk = 0;
    for (int len = 128; len > 0; len = len >> 1) begin
      for (int st = 0; st < N; st += 2 * len) begin
        kk++;
        z = zeta[kk];
        for (int j = st; j < st + len; j++) begin
          t = (z * v[j+len]) % Q;
          v[j+len] = (v[j] - t + Q) % Q;
          v[j] = (v[j] + t) % Q;
        end
      end
    end
    for (int i = 0; i < N; i++) fwd[i] = int'(v[i]);
  endtask

  task automatic load_img(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      load_coeff = 1'b1;
      load_addr  = AW'(i);
      load_data  = img[i];
      @(posedge clk); #1;
    end
    load_coeff = 1'b0;
  endtask

  task automatic read_check(input string tag);
    for (int i = 0; i < N; i++) begin
      read_addr = AW'(i);
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", tag, i), read_data, gold[i]);
    end
  endtask

  // Starts a run and watches 220 cycles; cycle 1 is the one after start is sampled.
  task automatic run(
    input  bit last_with_start,
    input  bit chk_tw,
    input  int inj_cyc,
    input  int rst_cyc,
    output int done_cyc,
    output int ndone,
    output int busy_bad
  );
    bit exp_busy;
    if (last_with_start) begin
      load_coeff = 1'b1;
      load_addr  = AW'(N - 1);
      load_data  = img[N-1];
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    load_coeff = 1'b0;
    done_cyc = -1;
    ndone = 0;
    busy_bad = 0;
    for (int c = 1; c <= 220; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      exp_busy = (rst_cyc > 0) ? (c <= rst_cyc) : (c <= DONE_AT);
      if (busy !== exp_busy) busy_bad++;
      if (chk_tw && c == 1) begin
        check("tw_s0_lane0", tw_addr[0 +: AW], 255);
        check("tw_s0_lane7", tw_addr[7*AW +: AW], 248);
      end
      if (chk_tw && c == 21) check("tw_s1_lane0", tw_addr[0 +: AW], 127);
      if (chk_tw && c == 161) check("tw_scale", tw_addr, 0);
      if (c == inj_cyc) begin
        start      = 1'b1;
        load_coeff = 1'b1;
        load_addr  = AW'(5);
        load_data  = 123;
      end
      if (c == rst_cyc) rst_n = 1'b0;
      @(posedge clk); #1;
      start      = 1'b0;
      load_coeff = 1'b0;
      rst_n      = 1'b1;
    end
  endtask

  int dc, nd, bb;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    load_coeff = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    read_addr  = '0;
    build_tables();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) img[i] = 1;
    load_img(N);
    read_addr = '0;
    @(posedge clk); #1;
    check("pre_reset_read", read_data, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_read_data", read_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);

    run(1'b0, 1'b0, 0, 0, dc, nd, bb);
    check("ones_done_cyc", dc, DONE_AT);
    check("ones_ndone", nd, 1);
    check("ones_busy", bb, 0);
    for (int i = 0; i < N; i++) gold[i] = (i == 0) ? 1 : 0;
    read_check("ones");

    for (int i = 0; i < N; i++) begin
      img[i]  = fwd[i];
      gold[i] = i;
    end
    load_img(N - 1);
    run(1'b1, 1'b1, 0, 0, dc, nd, bb);
    check("rt_done_cyc", dc, DONE_AT);
    check("rt_ndone", nd, 1);
    check("rt_busy", bb, 0);
    read_check("rt");

    load_img(N);
    run(1'b0, 1'b0, 40, 0, dc, nd, bb);
    check("ign_done_cyc", dc, DONE_AT);
    check("ign_ndone", nd, 1);
    check("ign_busy", bb, 0);
    read_check("ign");

    load_img(N);
    run(1'b0, 1'b0, 0, 50, dc, nd, bb);
    check("abort_ndone", nd, 0);
    check("abort_busy", bb, 0);
    load_img(N);
    run(1'b0, 1'b0, 0, 0, dc, nd, bb);
    check("rerun_done_cyc", dc, DONE_AT);
    check("rerun_ndone", nd, 1);
    check("rerun_busy", bb, 0);
    read_check("rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
